// File: rtl/key_cmd_sched.sv
// Turns held key levels into press/auto-repeat command events, arbitrated into a small FIFO.
// Auto-repeat is built only when KEY_REPEAT_EN is defined; otherwise each hold yields one press event.
//
// state     | meaning
// ST_IDLE   | key released, waiting for a press
// ST_DELAY  | pressed, counting down to the first auto-repeat   (KEY_REPEAT_EN)
// ST_REPEAT | auto-repeating, counting down to the next repeat  (KEY_REPEAT_EN)
// ST_HELD   | pressed, no further events until release          (no KEY_REPEAT_EN)
module key_cmd_sched #(
  parameter int DELAY_CYCLES  = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [4:0] key,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [2:0] cmd_code,
  output logic       cmd_rpt,
  output logic       evt_dropped
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;

  if (DELAY_CYCLES < 2 || REPEAT_CYCLES < 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_chk
    $error("key_cmd_sched: illegal parameter combination");
  end

`ifdef KEY_REPEAT_EN
  localparam int MAXC = (DELAY_CYCLES > REPEAT_CYCLES) ? DELAY_CYCLES : REPEAT_CYCLES;
  localparam int CW   = $clog2(MAXC);
  localparam logic [CW-1:0] DLY_LD = CW'(DELAY_CYCLES - 1);
  localparam logic [CW-1:0] RPT_LD = CW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} state_t;
  logic [CW-1:0] cnt_q [5];
  logic [CW-1:0] cnt_d [5];
`else
  typedef enum logic {ST_IDLE, ST_HELD} state_t;
`endif

  state_t state_q [5];
  state_t state_d [5];
  logic [4:0] evt, evt_rpt;

  logic [4:0] pend_q, pend_d, prpt_q, prpt_d;
  logic       drop_q, drop_d;

  logic [3:0]      mem_q [FIFO_DEPTH];
  logic [3:0]      mem_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;

  logic       push, pop, full, can_write, found;
  logic [2:0] gnt_code;
  logic [4:0] grant;
  logic [3:0] head;

  // Per-key event FSMs; release always wins over an event due in the same cycle.
  always_comb begin
    evt     = '0;
    evt_rpt = '0;
    for (int k = 0; k < 5; k++) begin
      state_d[k] = state_q[k];
`ifdef KEY_REPEAT_EN
      cnt_d[k] = cnt_q[k];
      case (state_q[k])
        ST_IDLE: begin
          if (key[k]) begin
            evt[k]     = 1'b1;
            state_d[k] = ST_DELAY;
            cnt_d[k]   = DLY_LD;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          if (!key[k]) begin
            state_d[k] = ST_IDLE;
            cnt_d[k]   = '0;
          end else if (cnt_q[k] == '0) begin
            evt[k]     = 1'b1;
            evt_rpt[k] = 1'b1;
            state_d[k] = ST_REPEAT;
            cnt_d[k]   = RPT_LD;
          end else begin
            cnt_d[k] = cnt_q[k] - 1'b1;
          end
        end
        default: begin
          state_d[k] = ST_IDLE;
          cnt_d[k]   = '0;
        end
      endcase
`else
      case (state_q[k])
        ST_IDLE: begin
          if (key[k]) begin
            evt[k]     = 1'b1;
            state_d[k] = ST_HELD;
          end
        end
        ST_HELD: begin
          if (!key[k]) state_d[k] = ST_IDLE;
        end
        default: state_d[k] = ST_IDLE;
      endcase
`endif
    end
  end

  assign pop       = (count_q != '0) && cmd_ready;
  assign full      = (count_q == CNTW'(FIFO_DEPTH));
  assign can_write = !full || pop;

  // Fixed priority: enter, then up, down, left, right.
  always_comb begin
    found    = 1'b0;
    gnt_code = 3'd0;
    grant    = '0;
    if (pend_q[4]) begin
      found    = 1'b1;
      gnt_code = 3'd4;
    end
    for (int k = 0; k < 4; k++) begin
      if (!found && pend_q[k]) begin
        found    = 1'b1;
        gnt_code = 3'(k);
      end
    end
    push = found && can_write;
    if (push) grant[gnt_code] = 1'b1;
  end

  always_comb begin
    pend_d = pend_q;
    prpt_d = prpt_q;
    drop_d = drop_q;
    for (int k = 0; k < 5; k++) begin
      if (grant[k]) pend_d[k] = 1'b0;
      if (evt[k]) begin
        if (pend_q[k] && !grant[k]) begin
          prpt_d[k] = prpt_q[k] | evt_rpt[k];
          drop_d    = 1'b1;
        end else begin
          prpt_d[k] = evt_rpt[k];
        end
        pend_d[k] = 1'b1;
      end
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {prpt_q[gnt_code], gnt_code};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < 5; k++) begin
        state_q[k] <= ST_IDLE;
`ifdef KEY_REPEAT_EN
        cnt_q[k]   <= '0;
`endif
      end
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      pend_q   <= '0;
      prpt_q   <= '0;
      drop_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int k = 0; k < 5; k++) begin
        state_q[k] <= state_d[k];
`ifdef KEY_REPEAT_EN
        cnt_q[k]   <= cnt_d[k];
`endif
      end
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
      pend_q   <= pend_d;
      prpt_q   <= prpt_d;
      drop_q   <= drop_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign cmd_valid   = (count_q != '0);
  assign cmd_code    = cmd_valid ? head[2:0] : 3'd0;
  // Without auto-repeat the stored repeat bit is always 0, so this is constant 0.
  assign cmd_rpt     = cmd_valid & head[3];
  assign evt_dropped = drop_q;

endmodule

// File: tb/tb_key_cmd_sched.sv
// Scoreboard bench for key_cmd_sched (DELAY=8, REPEAT=4, FIFO_DEPTH=4); follows KEY_REPEAT_EN of the build.
module tb_key_cmd_sched;

  logic       clk = 1'b0;
  logic       rstn;
  logic [4:0] key;
  logic       cmd_valid, cmd_ready, cmd_rpt, evt_dropped;
  logic [2:0] cmd_code;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [3:0] sb [$];
  int         hs_q [$];
  logic [3:0] exp_v;

  key_cmd_sched #(
    .DELAY_CYCLES (8),
    .REPEAT_CYCLES(4),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .key        (key),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_code   (cmd_code),
    .cmd_rpt    (cmd_rpt),
    .evt_dropped(evt_dropped)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes are judged mid-cycle, before the edge that accepts them.
  always @(negedge clk) begin
    if (rstn && cmd_valid && cmd_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: got code=%0d rpt=%0b, none expected (cyc %0d)",
                 cmd_code, cmd_rpt, cyc);
      end else begin
        exp_v = sb.pop_front();
        if ({cmd_rpt, cmd_code} !== exp_v) begin
          fails++;
          $display("FAIL event: got code=%0d rpt=%0b, expected code=%0d rpt=%0b (cyc %0d)",
                   cmd_code, cmd_rpt, exp_v[2:0], exp_v[3], cyc);
        end
      end
      hs_q.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_drained(input string name, input int n_exp);
    tests++;
    if (sb.size() != 0 || hs_q.size() != n_exp) begin
      fails++;
      $display("FAIL %s: got %0d events with %0d still expected, required %0d events",
               name, hs_q.size(), sb.size(), n_exp);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; key = '0; cmd_ready = 1'b1;
    step(2);
    tests++;
    if ({cmd_valid, cmd_code, cmd_rpt, evt_dropped} !== 6'b0) begin
      fails++;
      $display("FAIL reset_outputs: got valid=%0b code=%0d rpt=%0b drop=%0b, required all 0",
               cmd_valid, cmd_code, cmd_rpt, evt_dropped);
    end
    rstn = 1'b1;
    step(3);
    tests++;
    if (cmd_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got valid=%0b, required 0", cmd_valid);
    end
  endtask

  task automatic test_single_tap();
    hs_q.delete();
    key = 5'b00001;
    sb.push_back(4'h0);
    step(1);
    tests++;
    if (cmd_valid !== 1'b0) begin
      fails++;
      $display("FAIL tap_latency_e0: got valid=%0b, required 0", cmd_valid);
    end
    step(1);
    tests++;
    if ({cmd_valid, cmd_rpt, cmd_code} !== 5'b1_0_000) begin
      fails++;
      $display("FAIL tap_latency_e1: got valid=%0b code=%0d rpt=%0b, required 1/0/0",
               cmd_valid, cmd_code, cmd_rpt);
    end
    step(1);
    key = '0;
    step(10);
    check_drained("tap_count", 1);
  endtask

  task automatic test_hold();
    hs_q.delete();
`ifdef KEY_REPEAT_EN
    key = 5'b10000;
    sb.push_back(4'h4);
    sb.push_back(4'hC);
    sb.push_back(4'hC);
    sb.push_back(4'hC);
    step(20);
    key = '0;
    step(12);
    check_drained("hold_count", 4);
    tests++;
    if (hs_q.size() != 4) begin
      fails++;
      $display("FAIL hold_spacing: got %0d events, required 4", hs_q.size());
    end else if (hs_q[1] - hs_q[0] != 8 || hs_q[2] - hs_q[1] != 4 || hs_q[3] - hs_q[2] != 4) begin
      fails++;
      $display("FAIL hold_spacing: got gaps %0d,%0d,%0d, required 8,4,4",
               hs_q[1] - hs_q[0], hs_q[2] - hs_q[1], hs_q[3] - hs_q[2]);
    end
`else
    key = 5'b00001;
    sb.push_back(4'h0);
    step(30);
    key = '0;
    step(8);
    check_drained("hold_no_repeat", 1);
`endif
  endtask

  task automatic test_simultaneous();
    hs_q.delete();
    key = 5'b11111;
    sb.push_back(4'h4);
    sb.push_back(4'h0);
    sb.push_back(4'h1);
    sb.push_back(4'h2);
    sb.push_back(4'h3);
    step(1);
    key = '0;
    step(10);
    check_drained("simul_count", 5);
    tests++;
    if (hs_q.size() != 5 || hs_q[4] - hs_q[0] != 4) begin
      fails++;
      $display("FAIL simul_back_to_back: got %0d events, not on consecutive cycles", hs_q.size());
    end
    tests++;
    if (evt_dropped !== 1'b0) begin
      fails++;
      $display("FAIL simul_drop: got evt_dropped=%0b, required 0", evt_dropped);
    end
  endtask

  task automatic test_backpressure();
    hs_q.delete();
    cmd_ready = 1'b0;
`ifdef KEY_REPEAT_EN
    key = 5'b00010;
    step(40);
    key = '0;
    sb.push_back(4'h1);
    for (int i = 0; i < 4; i++) sb.push_back(4'h9);
`else
    for (int i = 0; i < 6; i++) begin
      key = 5'b00010;
      step(1);
      key = '0;
      step(1);
    end
    for (int i = 0; i < 5; i++) sb.push_back(4'h1);
`endif
    step(2);
    tests++;
    if (evt_dropped !== 1'b1 || cmd_valid !== 1'b1) begin
      fails++;
      $display("FAIL bp_coalesce: got evt_dropped=%0b valid=%0b, required 1/1",
               evt_dropped, cmd_valid);
    end
    cmd_ready = 1'b1;
    step(10);
    check_drained("bp_drain", 5);
    tests++;
    if (evt_dropped !== 1'b1) begin
      fails++;
      $display("FAIL bp_sticky: got evt_dropped=%0b, required 1", evt_dropped);
    end
  endtask

  task automatic test_reset_mid_hold();
    hs_q.delete();
    cmd_ready = 1'b0;
    key = 5'b00100;
    step(11);
    tests++;
    if (cmd_valid !== 1'b1) begin
      fails++;
      $display("FAIL rst_prefill: got valid=%0b, required 1", cmd_valid);
    end
    rstn = 1'b0;
    #1;
    tests++;
    if (cmd_valid !== 1'b0 || evt_dropped !== 1'b0) begin
      fails++;
      $display("FAIL rst_immediate: got valid=%0b drop=%0b, required 0/0", cmd_valid, evt_dropped);
    end
    step(2);
    rstn = 1'b1;
    sb.push_back(4'h2);
    cmd_ready = 1'b1;
    step(1);
    tests++;
    if (cmd_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_repress_e0: got valid=%0b, required 0", cmd_valid);
    end
    step(1);
    tests++;
    if ({cmd_valid, cmd_rpt, cmd_code} !== 5'b1_0_010) begin
      fails++;
      $display("FAIL rst_repress_e1: got valid=%0b code=%0d rpt=%0b, required 1/2/0",
               cmd_valid, cmd_code, cmd_rpt);
    end
    key = '0;
    step(6);
    check_drained("rst_count", 1);
  endtask

  initial begin
    test_reset();
    test_single_tap();
    test_hold();
    test_simultaneous();
    test_backpressure();
    test_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
